rf_save_ctrl: RTL and testbench

Save/restore sequencer for the 8-entry, 16-bit register file. On request it walks all registers through the register file's read port 1 into an internal shadow array (save), or writes the shadow array back through the write port (restore). While idle it passes the core's write port and read-1 select straight through to the register file. It sits between the core datapath and `rf`, and owns `rf`'s write port and read-1 select.

---
 rtl/rf_ctrl_pkg.sv | 15 +
 rtl/rf_shadow.sv | 38 +++
 rtl/rf_save_ctrl.sv | 115 +++++++++++
 tb/tb_rf_save_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the register-file save/restore controller.
package rf_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_W_DEF;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SAVE    = 2'd1;
  localparam state_t ST_RESTORE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/rf_shadow.sv
// Shadow copy of the register file: one sync write port, one comb read port,
// plus the flag marking that the copy holds a completed save.
module rf_shadow
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              valid_set,
  input  logic              valid_clr,
  output logic              valid
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];

  // Storage carries no reset; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid <= 1'b0;
    else if (valid_clr) valid <= 1'b0;
    else if (valid_set) valid <= 1'b1;
  end

endmodule

// File: rtl/rf_save_ctrl.sv
// Save/restore sequencer owning the register file write port and read-1
// select; passes the core's accesses through while idle.
module rf_save_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [ADDR_W-1:0] cpu_read1regsel,
  input  logic [ADDR_W-1:0] cpu_writeregsel,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] rf_read1data,
  output logic [ADDR_W-1:0] rf_read1regsel,
  output logic [ADDR_W-1:0] rf_writeregsel,
  output logic [DATA_W-1:0] rf_writedata,
  output logic              rf_write,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              shadow_valid
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              err_nxt;
  logic              cnt_last;
  logic              save_start;
  logic              save_end;
  logic [DATA_W-1:0] shadow_rdata;

  assign cnt_last   = &cnt;
  assign busy       = (state == ST_SAVE) || (state == ST_RESTORE);
  assign done       = (state == ST_DONE);
  assign save_start = (state == ST_IDLE) && save_req;
  assign save_end   = (state == ST_SAVE) && cnt_last;

  // Next state, counter and error condition
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (save_req) begin
          state_nxt = ST_SAVE;
        end else if (restore_req) begin
          if (shadow_valid) state_nxt = ST_RESTORE;
          else              err_nxt   = 1'b1;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        cnt_nxt = cnt + ADDR_W'(1);
        err_nxt = cpu_write;
        if (cnt_last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Register-file port muxing; core writes are dropped while busy
  always_comb begin
    rf_read1regsel = cpu_read1regsel;
    rf_writeregsel = cpu_writeregsel;
    rf_writedata   = cpu_writedata;
    rf_write       = cpu_write;
    case (state)
      ST_SAVE: begin
        rf_read1regsel = cnt;
        rf_write       = 1'b0;
      end
      ST_RESTORE: begin
        rf_writeregsel = cnt;
        rf_writedata   = shadow_rdata;
        rf_write       = 1'b1;
      end
      default: ;
    endcase
  end

  // A save in progress invalidates the previous copy until it completes
  rf_shadow #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (state == ST_SAVE),
    .waddr     (cnt),
    .wdata     (rf_read1data),
    .raddr     (cnt),
    .rdata     (shadow_rdata),
    .valid_set (save_end),
    .valid_clr (save_start),
    .valid     (shadow_valid)
  );

endmodule

// File: tb/tb_rf_save_ctrl.sv
// Bench for rf_save_ctrl with a behavioural register file attached to its
// rf_* ports and a scoreboard for the save reads and restore writes.
module tb_rf_save_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          save_req, restore_req;
  logic [AW-1:0] cpu_read1regsel, cpu_writeregsel;
  logic [DW-1:0] cpu_writedata;
  logic          cpu_write;
  logic [DW-1:0] rf_read1data;
  logic [AW-1:0] rf_read1regsel, rf_writeregsel;
  logic [DW-1:0] rf_writedata;
  logic          rf_write;
  logic          busy, done, err, shadow_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0]      rf_mem [NR];
  logic [DW-1:0]      exp_shadow [NR];
  bit                 exp_valid;
  logic [AW-1:0]      rd_q [$];
  logic [AW+DW-1:0]   wr_q [$];

  always #5 clk = ~clk;

  rf_save_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .save_req        (save_req),
    .restore_req     (restore_req),
    .cpu_read1regsel (cpu_read1regsel),
    .cpu_writeregsel (cpu_writeregsel),
    .cpu_writedata   (cpu_writedata),
    .cpu_write       (cpu_write),
    .rf_read1data    (rf_read1data),
    .rf_read1regsel  (rf_read1regsel),
    .rf_writeregsel  (rf_writeregsel),
    .rf_writedata    (rf_writedata),
    .rf_write        (rf_write),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .shadow_valid    (shadow_valid)
  );

  // Behavioural register file
  always @(posedge clk) if (rf_write) rf_mem[rf_writeregsel] <= rf_writedata;
  assign rf_read1data = rf_mem[rf_read1regsel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every busy cycle must match the next expected access
  always @(negedge clk) begin
    if (busy) begin
      if (rf_write) begin
        if (wr_q.size() == 0) chk("unexpected_rf_write", {13'd0, rf_writeregsel, rf_writedata}, 32'hFFFF_FFFF);
        else begin
          logic [AW+DW-1:0] e;
          e = wr_q.pop_front();
          chk("restore_wsel", 32'(rf_writeregsel), 32'(e[AW+DW-1:DW]));
          chk("restore_wdata", 32'(rf_writedata), 32'(e[DW-1:0]));
        end
      end else begin
        if (rd_q.size() == 0) chk("unexpected_busy_read", 32'(rf_read1regsel), 32'hFFFF_FFFF);
        else begin
          logic [AW-1:0] r;
          r = rd_q.pop_front();
          chk("save_rsel", 32'(rf_read1regsel), 32'(r));
        end
      end
    end
  end

  // Issue a request and observe 12 cycles; inj>0 raises a core write in that cycle
  task automatic run_op(input bit s, input bit r, input int inj,
                        output int nb, output int fb, output int nd,
                        output int dat, output int ne, output int eat);
    save_req = s;
    restore_req = r;
    if (s) begin
      for (int n = 0; n < NR; n++) begin
        rd_q.push_back(AW'(n));
        exp_shadow[n] = rf_mem[n];
      end
    end else if (r && exp_valid) begin
      for (int n = 0; n < NR; n++) wr_q.push_back({AW'(n), exp_shadow[n]});
    end
    @(posedge clk); #1;
    save_req = 0;
    restore_req = 0;
    nb = 0; fb = 0; nd = 0; dat = 0; ne = 0; eat = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == inj) begin
        cpu_write = 1'b1;
        cpu_writeregsel = 3'd3;
        cpu_writedata = 16'hBEEF;
      end else begin
        cpu_write = 1'b0;
      end
      @(negedge clk);
      if (busy) begin nb++; if (fb == 0) fb = i; end
      if (done) begin nd++; dat = i; end
      if (err)  begin ne++; eat = i; end
      @(posedge clk); #1;
    end
    cpu_write = 1'b0;
    if (s) exp_valid = 1'b1;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] wsel;
    logic [DW-1:0] wdata;
    logic [AW-1:0] rsel;
    logic [DW-1:0] exp_rdata;
    bit            chk_rdata;
  } vec_t;

  vec_t vecs [11];
  int nb, fb, nd, dat, ne, eat;

  initial begin
    // Passthrough vectors: preload Rn = 1110+n, then read a few back
    for (int n = 0; n < 8; n++)
      vecs[n] = '{1'b1, AW'(n), 16'h1110 + DW'(n), AW'(7 - n), 16'h0, 1'b0};
    vecs[8]  = '{1'b0, 3'd1, 16'h0000, 3'd0, 16'h1110, 1'b1};
    vecs[9]  = '{1'b0, 3'd2, 16'h5555, 3'd5, 16'h1115, 1'b1};
    vecs[10] = '{1'b0, 3'd6, 16'hAAAA, 3'd7, 16'h1117, 1'b1};

    rst_n = 1'b0;
    save_req = 0; restore_req = 0;
    cpu_read1regsel = 3'd4; cpu_writeregsel = 3'd6;
    cpu_writedata = 16'h0A0A; cpu_write = 1'b1;
    exp_valid = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_shadow_valid", 32'(shadow_valid), 0);
    chk("rst_pt_write", 32'(rf_write), 1);
    chk("rst_pt_wsel", 32'(rf_writeregsel), 6);
    chk("rst_pt_wdata", 32'(rf_writedata), 32'h0A0A);
    chk("rst_pt_rsel", 32'(rf_read1regsel), 4);
    cpu_write = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      cpu_write = vecs[k].wr;
      cpu_writeregsel = vecs[k].wsel;
      cpu_writedata = vecs[k].wdata;
      cpu_read1regsel = vecs[k].rsel;
      @(negedge clk);
      chk("pt_write", 32'(rf_write), 32'(vecs[k].wr));
      chk("pt_wsel", 32'(rf_writeregsel), 32'(vecs[k].wsel));
      chk("pt_wdata", 32'(rf_writedata), 32'(vecs[k].wdata));
      chk("pt_rsel", 32'(rf_read1regsel), 32'(vecs[k].rsel));
      if (vecs[k].chk_rdata) chk("pt_rdata", 32'(rf_read1data), 32'(vecs[k].exp_rdata));
      @(posedge clk); #1;
    end
    cpu_write = 1'b0;

    // Restore with no saved copy
    run_op(0, 1, 0, nb, fb, nd, dat, ne, eat);
    chk("norest_busy", 32'(nb), 0);
    chk("norest_done", 32'(nd), 0);
    chk("norest_err_cnt", 32'(ne), 1);
    chk("norest_err_at", 32'(eat), 1);
    for (int n = 0; n < NR; n++) chk("norest_rf", 32'(rf_mem[n]), 32'h1110 + 32'(n));

    // Save
    run_op(1, 0, 0, nb, fb, nd, dat, ne, eat);
    chk("save_busy_cnt", 32'(nb), 8);
    chk("save_busy_first", 32'(fb), 1);
    chk("save_done_cnt", 32'(nd), 1);
    chk("save_done_at", 32'(dat), 9);
    chk("save_err", 32'(ne), 0);
    chk("save_valid", 32'(shadow_valid), 1);
    for (int n = 0; n < NR; n++) chk("shadow_data", 32'(dut.u_shadow.mem[n]), 32'h1110 + 32'(n));

    // Clobber rf, then restore
    for (int n = 0; n < NR; n++) begin
      cpu_write = 1'b1; cpu_writeregsel = AW'(n); cpu_writedata = 16'hFFFF;
      @(posedge clk); #1;
    end
    cpu_write = 1'b0;
    chk("clobber_r5", 32'(rf_mem[5]), 32'hFFFF);
    run_op(0, 1, 0, nb, fb, nd, dat, ne, eat);
    chk("rest_busy_cnt", 32'(nb), 8);
    chk("rest_done_at", 32'(dat), 9);
    chk("rest_err", 32'(ne), 0);
    for (int n = 0; n < NR; n++) chk("rest_rf", 32'(rf_mem[n]), 32'h1110 + 32'(n));

    // Core write during save cycle 4 is dropped and flagged
    run_op(1, 0, 4, nb, fb, nd, dat, ne, eat);
    chk("cpuw_busy_cnt", 32'(nb), 8);
    chk("cpuw_err_cnt", 32'(ne), 1);
    chk("cpuw_err_at", 32'(eat), 5);
    chk("cpuw_r3", 32'(rf_mem[3]), 32'h1113);

    // Simultaneous requests: save wins
    run_op(1, 1, 0, nb, fb, nd, dat, ne, eat);
    chk("both_busy_cnt", 32'(nb), 8);
    chk("both_err", 32'(ne), 0);
    chk("both_valid", 32'(shadow_valid), 1);

    // Reset during restore cycle 5
    restore_req = 1'b1;
    for (int n = 0; n < NR; n++) wr_q.push_back({AW'(n), exp_shadow[n]});
    @(posedge clk); #1;
    restore_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_busy_before", 32'(busy), 1);
    cpu_read1regsel = 3'd5; cpu_writeregsel = 3'd2; cpu_writedata = 16'h1234; cpu_write = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_valid", 32'(shadow_valid), 0);
    chk("mid_rst_write", 32'(rf_write), 0);
    chk("mid_rst_wsel", 32'(rf_writeregsel), 2);
    chk("mid_rst_wdata", 32'(rf_writedata), 32'h1234);
    chk("mid_rst_rsel", 32'(rf_read1regsel), 5);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_q.delete();
    exp_valid = 1'b0;
    run_op(0, 1, 0, nb, fb, nd, dat, ne, eat);
    chk("post_rst_busy", 32'(nb), 0);
    chk("post_rst_err", 32'(ne), 1);

    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("wr_q_drained", 32'(wr_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
